highscore_table: RTL

- Clocked, parametrised high-score tracker for the whack-a-mole game.
- Keeps a sorted top-DEPTH table of binary scores. At each game end it ranks the final score with a sequential scan, then inserts it and shifts lower entries down.
- Drives a best-score output, a rank result and a 2-digit 7-segment status message.
- Sits between the game scorer and the display multiplexer.

---
 rtl/highscore_pkg.sv | 17 +
 rtl/highscore_if.sv | 31 +++
 rtl/hs_status_seg.sv | 28 ++
 rtl/highscore_table.sv | 127 ++++++++++++
 4 files changed

// File: rtl/highscore_pkg.sv
// Shared constants for the high-score table: 7-segment glyphs (active-low, gfedcba)
// and the controller state encoding.
package highscore_pkg;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_H    = 7'b0001001;
  localparam logic [6:0] SEG_I    = 7'b1111001;
  localparam logic [6:0] SEG_U    = 7'b1000001;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_O    = 7'b0100011;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

endpackage

// File: rtl/highscore_if.sv
// Game-side bus of the high-score table: game-over strobe, table read port and
// result/status outputs. master = scorer/display side, slave = table.
interface highscore_if #(
  parameter int SCORE_W = 7,
  parameter int DEPTH   = 4
);
  localparam int IW = $clog2(DEPTH);
  localparam int RW = $clog2(DEPTH + 1);

  logic               game_over;
  logic [SCORE_W-1:0] final_score;
  logic [IW-1:0]      rd_idx;
  logic [SCORE_W-1:0] rd_score;
  logic [SCORE_W-1:0] best_score;
  logic               busy;
  logic               done;
  logic [RW-1:0]      rank;
  logic               new_record;
  logic [6:0]         seg_hi;
  logic [6:0]         seg_lo;

  modport master (
    output game_over, final_score, rd_idx,
    input  rd_score, best_score, busy, done, rank, new_record, seg_hi, seg_lo
  );

  modport slave (
    input  game_over, final_score, rd_idx,
    output rd_score, best_score, busy, done, rank, new_record, seg_hi, seg_lo
  );
endinterface

// File: rtl/hs_status_seg.sv
// Maps the ranking result to a 2-digit status message: "HI", "UP", "bo", or "--"
// when no result is being presented.
module hs_status_seg
  import highscore_pkg::*;
(
  input  logic       valid,
  input  logic       is_top,
  input  logic       no_place,
  output logic [6:0] seg_hi,
  output logic [6:0] seg_lo
);
  always_comb begin
    seg_hi = SEG_DASH;
    seg_lo = SEG_DASH;
    if (valid) begin
      if (is_top) begin
        seg_hi = SEG_H;
        seg_lo = SEG_I;
      end else if (no_place) begin
        seg_hi = SEG_B;
        seg_lo = SEG_O;
      end else begin
        seg_hi = SEG_U;
        seg_lo = SEG_P;
      end
    end
  end
endmodule

// File: rtl/highscore_table.sv
// Sorted top-DEPTH score table: sequential rank scan, then one-cycle insert/shift.
// Define HIGHSCORE_TIE_EN to let a tying score place above the equal entry.
module highscore_table
  import highscore_pkg::*;
#(
  parameter int SCORE_W    = 7,
  parameter int DEPTH      = 4,
  parameter int INIT_SCORE = 2
)(
  input  logic        clk,
  input  logic        reset,
  highscore_if.slave  bus
);
  localparam int IW   = $clog2(DEPTH);
  localparam int RW   = $clog2(DEPTH + 1);
  localparam int RD_N = 1 << IW;

  logic [1:0]                      state;
  logic [DEPTH-1:0][SCORE_W-1:0]   tbl;
  logic [DEPTH-1:0][SCORE_W-1:0]   tbl_ins;
  logic [RD_N-1:0][SCORE_W-1:0]    rd_arr;
  logic [SCORE_W-1:0]              cand;
  logic [IW-1:0]                   idx;
  logic [IW-1:0]                   pos;
  logic                            hit;
  logic                            beats;
  logic                            busy;
  logic                            done;
  logic [RW-1:0]                   rank;
  logic                            new_record;
  logic [6:0]                      seg_hi, seg_lo;
  logic [6:0]                      seg_hi_nxt, seg_lo_nxt;

`ifdef HIGHSCORE_TIE_EN
  assign beats = cand >= tbl[idx];
`else
  assign beats = cand > tbl[idx];
`endif

  // Table after inserting cand at pos; the old last entry falls off the end.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ins
    if (k == 0) begin : g_head
      assign tbl_ins[k] = (pos == '0) ? cand : tbl[k];
    end else begin : g_body
      assign tbl_ins[k] = (IW'(k) == pos) ? cand :
                          (IW'(k) >  pos) ? tbl[k-1] : tbl[k];
    end
  end

  // Pad the read port to a power of two so out-of-range indices read zero.
  for (genvar i = 0; i < RD_N; i++) begin : g_rd
    if (i < DEPTH) begin : g_live
      assign rd_arr[i] = tbl[i];
    end else begin : g_pad
      assign rd_arr[i] = '0;
    end
  end

  hs_status_seg u_seg (
    .valid    (state == ST_UPDATE),
    .is_top   (hit && (pos == '0)),
    .no_place (!hit),
    .seg_hi   (seg_hi_nxt),
    .seg_lo   (seg_lo_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++)
        tbl[k] <= (k == 0) ? SCORE_W'(INIT_SCORE) : '0;
      state      <= ST_IDLE;
      cand       <= '0;
      idx        <= '0;
      pos        <= '0;
      hit        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rank       <= RW'(DEPTH);
      new_record <= 1'b0;
      seg_hi     <= SEG_DASH;
      seg_lo     <= SEG_DASH;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.game_over) begin
            cand  <= bus.final_score;
            idx   <= '0;
            hit   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // First (highest) entry beaten wins; later matches would rank lower.
          if (!hit && beats) begin
            pos <= idx;
            hit <= 1'b1;
          end
          if (idx == IW'(DEPTH - 1)) state <= ST_UPDATE;
          else                       idx   <= idx + 1'b1;
        end
        ST_UPDATE: begin
          if (hit) tbl <= tbl_ins;
          rank       <= hit ? RW'(pos) : RW'(DEPTH);
          new_record <= hit && (pos == '0);
          seg_hi     <= seg_hi_nxt;
          seg_lo     <= seg_lo_nxt;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_score   = rd_arr[bus.rd_idx];
  assign bus.best_score = tbl[0];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.rank       = rank;
  assign bus.new_record = new_record;
  assign bus.seg_hi     = seg_hi;
  assign bus.seg_lo     = seg_lo;

endmodule
